// File: rtl/disp_mux_n.sv
`default_nettype none
// ============================================================================
// Module   : disp_mux_n
// Purpose  : Time-multiplexed common-anode 7-segment driver with dead-time
//            blanking and per-frame input snapshot. Optional PWM brightness
//            is enabled by defining DISP_MUX_BRIGHT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module disp_mux_n #(
    parameter int NUM_DIGITS = 4,
    parameter int SEG_W      = 8,
    parameter int TICK_W     = 16,
    parameter int DEAD_CYC   = 64,
    parameter int BRIGHT_W   = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_DIGITS*SEG_W-1:0] digits,
    input  logic [NUM_DIGITS-1:0]       blank,
`ifdef DISP_MUX_BRIGHT_EN
    input  logic [BRIGHT_W-1:0]         bright,
`endif
    output logic [NUM_DIGITS-1:0]       an,
    output logic [SEG_W-1:0]            sseg,
    output logic                        frame_start
);

    localparam int                IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [TICK_W-1:0] c_TICK_MAX = '1;
    localparam logic [IDX_W-1:0]  c_IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [TICK_W-1:0]           tick_q, tick_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic                        init_q;
    logic [NUM_DIGITS*SEG_W-1:0] dig_q;
    logic [NUM_DIGITS-1:0]       blank_q;
    logic [NUM_DIGITS-1:0]       an_q, an_d;
    logic [SEG_W-1:0]            sseg_q, sseg_d;
    logic                        fs_q, fs_d;

    logic                        tick_wrap;
    logic                        capture_en;
    logic                        dead;
    logic                        gate;
    logic                        lit;
    logic [SEG_W-1:0]            seg_sel;
    logic                        blank_sel;

    assign tick_wrap  = (tick_q == c_TICK_MAX);
    assign capture_en = init_q | (tick_wrap & (idx_q == c_IDX_LAST));
    assign tick_d     = tick_q + 1'b1;
    assign idx_d      = !tick_wrap ? idx_q :
                        (idx_q == c_IDX_LAST) ? '0 : idx_q + 1'b1;

    generate
        if (DEAD_CYC == 0) begin : g_no_dead
            assign dead = 1'b0;
        end else begin : g_dead
            assign dead = (tick_q < TICK_W'(DEAD_CYC));
        end
    endgenerate

`ifdef DISP_MUX_BRIGHT_EN
    logic [BRIGHT_W-1:0] bright_q;

    // The top BRIGHT_W tick bits form a sawtooth that the code is compared against.
    assign gate = (tick_q[TICK_W-1 -: BRIGHT_W] <= bright_q);
`else
    logic [BRIGHT_W-1:0] bright_unused;

    assign bright_unused = '0;
    assign gate          = 1'b1;
`endif

    always_comb begin
        seg_sel   = '1;
        blank_sel = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                seg_sel   = dig_q[k*SEG_W +: SEG_W];
                blank_sel = blank_q[k];
            end
        end
    end

    assign lit    = ~dead & ~blank_sel & gate;
    assign an_d   = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    assign sseg_d = lit ? seg_sel : '1;
    assign fs_d   = (tick_q == '0) && (idx_q == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q   <= '0;
            idx_q    <= '0;
            init_q   <= 1'b1;
            dig_q    <= '1;
            blank_q  <= '1;
            an_q     <= '1;
            sseg_q   <= '1;
            fs_q     <= 1'b0;
`ifdef DISP_MUX_BRIGHT_EN
            bright_q <= '1;
`endif
        end else begin
            tick_q   <= tick_d;
            idx_q    <= idx_d;
            init_q   <= 1'b0;
            an_q     <= an_d;
            sseg_q   <= sseg_d;
            fs_q     <= fs_d;
            if (capture_en) begin
                dig_q    <= digits;
                blank_q  <= blank;
`ifdef DISP_MUX_BRIGHT_EN
                bright_q <= bright;
`endif
            end
        end
    end

    assign an          = an_q;
    assign sseg        = sseg_q;
    assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: doc/disp_mux_n.md
Name: disp_mux_n

Overview:
- Parametrised time-multiplexed seven-segment display driver; successor to the fixed 4-digit multiplexer.
- Scans NUM_DIGITS common-anode digits with registered, glitch-free outputs and an inter-digit dead-time blanking interval that prevents ghosting.
- Inputs are snapshotted once per frame, so a display never tears mid-scan.
- Supports per-digit blanking and optional PWM brightness control.
- Sits between the display-formatting logic (hex/BCD-to-segment encoders) and the board pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; 1..16, need not be a power of two.
- SEG_W, 8: segment bits per digit (7 segments + dp); active-low.
- TICK_W, 16: slot counter width; each digit is driven for 2^TICK_W clk cycles.
- DEAD_CYC, 64: blank cycles at the start of every slot; 0 <= DEAD_CYC < 2^TICK_W.
- BRIGHT_W, 4: brightness code width; used only with DISP_MUX_BRIGHT_EN.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- digits  input  NUM_DIGITS*SEG_W  segment patterns; digit k occupies bits [k*SEG_W +: SEG_W].
- blank  input  NUM_DIGITS  1 = digit k dark for the whole frame.
- bright  input  BRIGHT_W  brightness code; present only with DISP_MUX_BRIGHT_EN.
- an  output  NUM_DIGITS  digit enables, active-low, at most one bit low.
- sseg  output  SEG_W  segment drive, active-low.
- frame_start  output  1  one-cycle pulse aligned with the first output cycle of the digit 0 slot.

Behaviour:
- Reset is asynchronous and active-low.
  - While reset_n is 0: tick=0, idx=0, an=all ones, sseg=all ones, frame_start=0.
  - Shadow digits reset to all ones and shadow blank resets to all ones.
- Slot counter tick (TICK_W bits) increments every cycle and wraps from 2^TICK_W-1 to 0.
- On each tick wrap, idx advances; idx wraps from NUM_DIGITS-1 to 0. idx never takes values >= NUM_DIGITS.
- Snapshot (capture_en): shadow digits and shadow blank load from the inputs in the cycle where tick=max and idx=NUM_DIGITS-1.
  - They also load in the first cycle after reset release, via an init flag that is set by reset and cleared after one cycle.
  - Between snapshots, input changes have no visible effect.
- Per-cycle FSM, derived combinationally from tick:
  - DEAD while tick < DEAD_CYC.
  - ON otherwise.
  - DEAD_CYC=0 means DEAD never occurs.
- Next outputs:
  - If DEAD, or shadow blank[idx]=1, or the PWM gate is off: an=all ones, sseg=all ones.
  - Otherwise: an = all ones with bit idx cleared; sseg = shadow digit idx.
- Latency: an, sseg and frame_start are registered and reflect the tick/idx/shadow values of the previous cycle, i.e. one clk of latency.
- frame_start = 1 for exactly one cycle when the registered outputs correspond to idx=0, tick=0. This includes the first post-reset frame.
- In the first cycle after reset release, outputs use the reset shadow values, so the display is blank. The new snapshot is visible from the next cycle.
- Outputs change only on clk edges. an never has two bits low. Every digit change passes through at least DEAD_CYC all-high cycles.
- Reset asserted mid-frame: outputs go immediately (asynchronously) to all ones. Scanning restarts at idx=0 after release.

Optional Feature:
- Macro: DISP_MUX_BRIGHT_EN.
- Defined:
  - The bright port exists.
  - The PWM gate is on when tick[TICK_W-1 -: BRIGHT_W] <= bright. bright=all ones gives 100% of the ON phase; bright=0 gives about 1/2^BRIGHT_W.
  - bright is captured into the shadow with the other inputs.
  - Requires BRIGHT_W <= TICK_W.
- Undefined:
  - No bright port.
  - The PWM gate is always on.
  - BRIGHT_W is ignored.

Test Plan:
- Reset and blank-first-cycle check (sim params NUM_DIGITS=3, TICK_W=4, DEAD_CYC=2):
  - Stimulus: digits={8'h11,8'h22,8'h33}, blank=0; release reset.
  - Required: an=3'b111 for the first 3 output cycles (1 init + 2 dead).
  - Then an=3'b110 and sseg=8'h33 for 14 cycles, then 2 dead cycles, then an=3'b101 and sseg=8'h22.
  - idx wraps after digit 2 (non-power-of-two depth).
- Snapshot: change digits mid-frame to all 8'h00.
  - Required: the old values are displayed until the frame ends; 8'h00 appears starting from the digit 0 slot.
  - frame_start pulses exactly once per 3*16=48 cycles.
- Blanking: blank=3'b010.
  - Required: throughout the digit 1 slot, an=3'b111 and sseg=8'hFF; digits 0 and 2 are unaffected.
- Async reset mid-slot: assert reset_n=0 between clock edges while an=3'b101.
  - Required: an=3'b111 and sseg=8'hFF before the next edge; after release, scanning restarts at digit 0.
- DISP_MUX_BRIGHT_EN, BRIGHT_W=2, TICK_W=4, DEAD_CYC=0:
  - bright=2'd1: each slot is lit for tick 0..7 (8 of 16 cycles).
  - bright=2'd3: lit for all 16 cycles.
  - bright=2'd0: lit for tick 0..3 only.
- Invariant checker over 10^5 random cycles with random inputs:
  - popcount(~an) <= 1.
  - At least DEAD_CYC all-high cycles between any two distinct low an bits.
